// File: rtl/hazard_ctl_pkg.sv
// hazard_ctl_pkg: shared state encodings and widths for the hvcore hazard controller
package hazard_ctl_pkg;
    typedef enum logic [1:0] {
        HZ_RUN       = 2'd0,
        HZ_DMEM_WAIT = 2'd1,
        HZ_FLUSH     = 2'd2
    } hz_state_e;
    localparam int REG_AW = 4;
endpackage

// File: rtl/hazard_ctl_if.sv
// hazard_ctl_if: decode/memory/write-back status in, pipeline control out
interface hazard_ctl_if import hazard_ctl_pkg::*; ();
    logic              instr_valid_i;
    logic              dec_ren_a_i;
    logic              dec_ren_b_i;
    logic [REG_AW-1:0] dec_reg_a_idx_i;
    logic [REG_AW-1:0] dec_reg_b_idx_i;
    logic              dec_wen_d_i;
    logic [REG_AW-1:0] dec_reg_d_idx_i;
    logic              change_pc_i;
    logic              dmem_en_i;
    logic              dmem_rdata_valid_i;
    logic              pc_halt_o;
    logic              dec_hold_o;
    logic              bubble_o;
    logic              flush_o;
    logic [1:0]        state_o;
    modport master (
        output instr_valid_i, dec_ren_a_i, dec_ren_b_i, dec_reg_a_idx_i, dec_reg_b_idx_i,
               dec_wen_d_i, dec_reg_d_idx_i, change_pc_i, dmem_en_i, dmem_rdata_valid_i,
        input  pc_halt_o, dec_hold_o, bubble_o, flush_o, state_o
    );
    modport slave (
        input  instr_valid_i, dec_ren_a_i, dec_ren_b_i, dec_reg_a_idx_i, dec_reg_b_idx_i,
               dec_wen_d_i, dec_reg_d_idx_i, change_pc_i, dmem_en_i, dmem_rdata_valid_i,
        output pc_halt_o, dec_hold_o, bubble_o, flush_o, state_o
    );
endinterface

// File: rtl/hz_scoreboard.sv
// hz_scoreboard: in-flight register-write shift register with RAW match against decode sources
module hz_scoreboard #(
    parameter int DEPTH = 3,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          freeze,
    input  logic          clr_young,
    input  logic          load_valid,
    input  logic [AW-1:0] load_idx,
    input  logic          ren_a,
    input  logic [AW-1:0] idx_a,
    input  logic          ren_b,
    input  logic [AW-1:0] idx_b,
    output logic          hazard
);
    logic [DEPTH-1:0] vld;
    logic [AW-1:0]    idx [DEPTH];
    // the oldest entry survives a redirect: it is the write retiring now
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) idx[i] <= '0;
        end else if (clr_young) begin
            vld[DEPTH-2:0] <= '0;
        end else if (!freeze) begin
            vld    <= {vld[DEPTH-2:0], load_valid};
            idx[0] <= load_idx;
            for (int i = 1; i < DEPTH; i++) idx[i] <= idx[i-1];
        end
    end
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            hazard |= vld[i] & ((ren_a & (idx[i] == idx_a) & (|idx_a)) |
                                (ren_b & (idx[i] == idx_b) & (|idx_b)));
    end
endmodule

// File: rtl/hazard_ctl.sv
// hazard_ctl: stall/flush sequencing FSM for the fetch/decode/execute/write-back pipeline
module hazard_ctl import hazard_ctl_pkg::*; #(
    parameter int DEPTH        = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input logic         clk,
    input logic         rst_n,
    hazard_ctl_if.slave bus
);
    localparam int             CW       = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);
    hz_state_e       state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            halt, hold, bub, fl, freeze, clr, hazard;
    hz_scoreboard #(.DEPTH(DEPTH), .AW(REG_AW)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .freeze     (freeze),
        .clr_young  (clr),
        .load_valid (bus.dec_wen_d_i & ~bub & ~fl),
        .load_idx   (bus.dec_reg_d_idx_i),
        .ren_a      (bus.dec_ren_a_i),
        .idx_a      (bus.dec_reg_a_idx_i),
        .ren_b      (bus.dec_ren_b_i),
        .idx_b      (bus.dec_reg_b_idx_i),
        .hazard     (hazard)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HZ_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        halt      = 1'b0;
        hold      = 1'b0;
        bub       = 1'b0;
        fl        = 1'b0;
        freeze    = 1'b0;
        clr       = 1'b0;
        case (state)
            HZ_RUN: begin
                if (bus.change_pc_i) begin
                    state_nxt = HZ_FLUSH;
                    cnt_nxt   = CNT_LOAD;
                    clr       = 1'b1;
                end else if (bus.dmem_en_i && !bus.dmem_rdata_valid_i) begin
                    state_nxt = HZ_DMEM_WAIT;
                    halt      = 1'b1;
                    hold      = 1'b1;
                    freeze    = 1'b1;
                end else if (hazard) begin
                    halt = 1'b1;
                    hold = 1'b1;
                    bub  = 1'b1;
                end else if (!bus.instr_valid_i) begin
                    halt = 1'b1;
                    bub  = 1'b1;
                end
            end
            HZ_DMEM_WAIT: begin
                halt   = 1'b1;
                hold   = 1'b1;
                freeze = 1'b1;
                if (bus.change_pc_i) begin
                    state_nxt = HZ_FLUSH;
                    cnt_nxt   = CNT_LOAD;
                    clr       = 1'b1;
                end else if (bus.dmem_rdata_valid_i) begin
                    state_nxt = HZ_RUN;
                end
            end
            HZ_FLUSH: begin
                fl  = 1'b1;
                bub = 1'b1;
                if (bus.change_pc_i) begin
                    cnt_nxt = CNT_LOAD;
                    clr     = 1'b1;
                end else if (cnt == '0) begin
                    state_nxt = HZ_RUN;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = HZ_RUN;
        endcase
    end
    // outputs are forced low while reset is held, independent of live inputs
    assign bus.pc_halt_o  = halt & rst_n;
    assign bus.dec_hold_o = hold & rst_n;
    assign bus.bubble_o   = bub & rst_n;
    assign bus.flush_o    = fl & rst_n;
    assign bus.state_o    = state;
endmodule

// File: tb/tb_hazard_ctl.sv
// tb_hazard_ctl: table-driven check of hazard_ctl stalls, flush window and reset behaviour
module tb_hazard_ctl;
    typedef struct {
        logic       iv, ra, rb, wd, cpc, de, drv;
        logic [3:0] ia, ib, id;
        logic [5:0] exp;
    } vec_t;

    localparam logic [5:0] E0  = 6'b000000;
    localparam logic [5:0] EH  = 6'b111000;
    localparam logic [5:0] EM  = 6'b101000;
    localparam logic [5:0] ED0 = 6'b110000;
    localparam logic [5:0] ED  = 6'b110001;
    localparam logic [5:0] EF  = 6'b001110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    logic [5:0] exp_q[$];
    vec_t tbl[$];

    hazard_ctl_if bus();
    hazard_ctl #(.DEPTH(3), .FLUSH_CYCLES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic vec_t v(input logic iv, ra, input logic [3:0] ia, input logic rb,
                               input logic [3:0] ib, input logic wd, input logic [3:0] id,
                               input logic cpc, de, drv, input logic [5:0] exp);
        vec_t t;
        t.iv = iv; t.ra = ra; t.ia = ia; t.rb = rb; t.ib = ib; t.wd = wd; t.id = id;
        t.cpc = cpc; t.de = de; t.drv = drv; t.exp = exp;
        return t;
    endfunction

    function automatic logic [5:0] act();
        return {bus.pc_halt_o, bus.dec_hold_o, bus.bubble_o, bus.flush_o, bus.state_o};
    endfunction

    task automatic chk(input string nm, input logic [5:0] got, input logic [5:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got {halt,hold,bub,flush,state}=%b expected %b", nm, got, want);
    endtask

    task automatic drive(input vec_t t);
        bus.instr_valid_i      = t.iv;
        bus.dec_ren_a_i        = t.ra;
        bus.dec_reg_a_idx_i    = t.ia;
        bus.dec_ren_b_i        = t.rb;
        bus.dec_reg_b_idx_i    = t.ib;
        bus.dec_wen_d_i        = t.wd;
        bus.dec_reg_d_idx_i    = t.id;
        bus.change_pc_i        = t.cpc;
        bus.dmem_en_i          = t.de;
        bus.dmem_rdata_valid_i = t.drv;
    endtask

    task automatic step(input vec_t t, input string nm);
        @(posedge clk);
        #1;
        drive(t);
        exp_q.push_back(t.exp);
        @(negedge clk);
        chk(nm, act(), exp_q.pop_front());
    endtask

    initial begin
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E0));
        #3;
        chk("reset_state", act(), E0);
        #9 rst_n = 1'b1;
        // back-to-back dependency on r3: three bubbles then release
        tbl.push_back(v(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, E0));
        tbl.push_back(v(1, 1, 3, 0, 0, 1, 5, 0, 0, 0, EH));
        tbl.push_back(v(1, 1, 3, 0, 0, 1, 5, 0, 0, 0, EH));
        tbl.push_back(v(1, 1, 3, 0, 0, 1, 5, 0, 0, 0, EH));
        tbl.push_back(v(1, 1, 3, 0, 0, 1, 5, 0, 0, 0, E0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E0));
        // independent r1 write / r2 read, then a delayed r1 read on port b
        tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, E0));
        tbl.push_back(v(1, 1, 2, 1, 2, 0, 0, 0, 0, 0, E0));
        tbl.push_back(v(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, EH));
        tbl.push_back(v(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, EH));
        tbl.push_back(v(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, E0));
        // r0 is never hazardous
        tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, E0));
        tbl.push_back(v(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, E0));
        // fetch miss: bubbles, no entry for the r7 write
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 7, 0, 0, 0, EM));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 7, 0, 0, 0, EM));
        tbl.push_back(v(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, E0));
        // dmem wait beats hazard; scoreboard frozen through the wait
        tbl.push_back(v(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, E0));
        tbl.push_back(v(1, 1, 4, 0, 0, 0, 0, 0, 1, 0, ED0));
        tbl.push_back(v(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, ED));
        tbl.push_back(v(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, ED));
        tbl.push_back(v(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, ED));
        tbl.push_back(v(1, 1, 4, 0, 0, 0, 0, 0, 0, 1, ED));
        tbl.push_back(v(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, EH));
        tbl.push_back(v(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, EH));
        tbl.push_back(v(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, EH));
        tbl.push_back(v(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, E0));
        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));
        // redirect with a pending hazard: flush wins, young entries cleared
        step(v(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, E0), "fl_w6");
        step(v(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, E0), "fl_w9");
        step(v(1, 1, 9, 0, 0, 1, 10, 1, 0, 0, E0), "fl_cpc_haz");
        step(v(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, EF), "fl_cyc1");
        step(v(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, EF), "fl_cyc2");
        step(v(1, 1, 9, 1, 6, 0, 0, 0, 0, 0, E0), "fl_done_r9r6");
        step(v(1, 1, 10, 0, 0, 0, 0, 0, 0, 0, E0), "fl_done_r10");
        // asynchronous reset in the first flush cycle
        step(v(1, 0, 0, 0, 0, 1, 8, 0, 0, 0, E0), "rs_w8");
        step(v(1, 0, 0, 0, 0, 1, 11, 1, 0, 0, E0), "rs_cpc");
        step(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, EF), "rs_flush");
        #1;
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E0));
        rst_n = 1'b0;
        #1;
        chk("rs_async", act(), E0);
        @(posedge clk);
        #1;
        chk("rs_held", act(), E0);
        rst_n = 1'b1;
        step(v(1, 1, 8, 1, 11, 0, 0, 0, 0, 0, E0), "rs_nohaz");
        step(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E0), "rs_idle");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
